// File: rtl/gan_pkg.sv
// rtl/gan_pkg.sv - shared Q8.24 constants, frame size, FSM encoding and saturation helper
package gan_pkg;

  localparam int Q_W = 32;
  localparam logic signed [Q_W-1:0] Q_ONE  = 32'sh01000000;
  localparam logic signed [Q_W-1:0] Q_ZERO = 32'sh00000000;
  localparam logic signed [Q_W-1:0] Q_HALF = 32'sh00800000;

  localparam int FRAME_PIX = 9;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_STREAM = S_STREAM,
    ST_DONE   = S_DONE
  } ser_state_t;

  // Clamp a wide signed value to the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/gan_frame_serializer_if.sv
// rtl/gan_frame_serializer_if.sv - capture strobe, beat stream and status bundle of the frame serializer
interface gan_frame_serializer_if #(parameter int WIDTH = 32);
  import gan_pkg::*;

  logic                         start;
  logic [FRAME_PIX*WIDTH-1:0]   pix_in;
  logic signed [WIDTH-1:0]      disc_in;
  logic                         out_ready;
  logic                         out_valid;
  logic signed [WIDTH-1:0]      out_data;
  logic                         out_bit;
  logic [3:0]                   out_idx;
  logic                         out_last;
  logic                         busy;
  logic                         verdict;
  logic                         frame_done;
  logic                         overrun;

  modport master (
    output start, pix_in, disc_in, out_ready,
    input  out_valid, out_data, out_bit, out_idx, out_last,
    input  busy, verdict, frame_done, overrun
  );

  modport slave (
    input  start, pix_in, disc_in, out_ready,
    output out_valid, out_data, out_bit, out_idx, out_last,
    output busy, verdict, frame_done, overrun
  );

endinterface

// File: rtl/gan_sat_adder9.sv
// rtl/gan_sat_adder9.sv - sum of nine signed words with 4 guard bits, saturated back to WIDTH
module gan_sat_adder9
  import gan_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [FRAME_PIX*WIDTH-1:0] i_pix,
  output logic signed [WIDTH-1:0]    o_sum
);

  localparam int ACC_W = WIDTH + 4;

  logic signed [ACC_W-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int k = 0; k < FRAME_PIX; k++) begin
      w_acc = w_acc + ACC_W'($signed(i_pix[k*WIDTH +: WIDTH]));
    end
    o_sum = WIDTH'(saturate(64'(w_acc), WIDTH));
  end

endmodule

// File: rtl/gan_frame_serializer.sv
// rtl/gan_frame_serializer.sv - latches a 3x3 Q8.24 frame plus score and streams it one pixel per beat
// Optional checksum beat (idx 9) enabled by defining GAN_SERIALIZER_CHECKSUM_EN.
module gan_frame_serializer
  import gan_pkg::*;
#(
  parameter int                      WIDTH       = 32,
  parameter logic signed [WIDTH-1:0] PIX_THRESH  = 32'sh00800000,
  parameter logic signed [WIDTH-1:0] DISC_THRESH = 32'sh00800000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  gan_frame_serializer_if.slave  bus
);

`ifdef GAN_SERIALIZER_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'd9;
`else
  localparam logic [3:0] LAST = 4'd8;
`endif

  ser_state_t                  r_state;
  logic [FRAME_PIX*WIDTH-1:0]  r_frame;
  logic [3:0]                  r_idx;
  logic signed [WIDTH-1:0]     r_data;
  logic                        r_bit;
  logic                        r_last;
  logic                        r_verdict;
  logic                        r_overrun;

  logic [3:0]                  w_nidx;
  logic signed [WIDTH-1:0]     w_ndata;
  logic                        w_nbit;
  logic signed [WIDTH-1:0]     w_pix0;

  assign w_pix0 = $signed(bus.pix_in[WIDTH-1:0]);

`ifdef GAN_SERIALIZER_CHECKSUM_EN
  logic signed [WIDTH-1:0] w_sum;

  gan_sat_adder9 #(.WIDTH(WIDTH)) u_sum (
    .i_pix (r_frame),
    .o_sum (w_sum)
  );
`endif

  // Next beat is prepared from the latched frame so the outputs are pure registers.
  always_comb begin
    w_nidx  = r_idx + 4'd1;
    w_ndata = '0;
    w_nbit  = 1'b0;
    if (w_nidx < 4'(FRAME_PIX)) begin
      w_ndata = $signed(r_frame[int'(w_nidx)*WIDTH +: WIDTH]);
      w_nbit  = (w_ndata >= PIX_THRESH);
    end
`ifdef GAN_SERIALIZER_CHECKSUM_EN
    else begin
      w_ndata = w_sum;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_idx     <= '0;
      r_data    <= '0;
      r_bit     <= 1'b0;
      r_last    <= 1'b0;
      r_verdict <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= bus.start && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_frame   <= bus.pix_in;
            r_verdict <= (bus.disc_in >= DISC_THRESH);
            r_idx     <= '0;
            r_data    <= w_pix0;
            r_bit     <= (w_pix0 >= PIX_THRESH);
            r_last    <= 1'b0;
            r_state   <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (bus.out_ready) begin
            if (r_last) begin
              r_state <= ST_DONE;
            end else begin
              r_idx  <= w_nidx;
              r_data <= w_ndata;
              r_bit  <= w_nbit;
              r_last <= (w_nidx == LAST);
            end
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid  = (r_state == ST_STREAM);
  assign bus.out_data   = r_data;
  assign bus.out_bit    = r_bit;
  assign bus.out_idx    = r_idx;
  assign bus.out_last   = r_last;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.verdict    = r_verdict;
  assign bus.frame_done = (r_state == ST_DONE);
  assign bus.overrun    = r_overrun;

endmodule
